// File: rtl/ift_sr_monitor.sv
// Runtime monitor for an SR cell with information-flow taint: compares the cell's Q/Q_t
// against a reference model over a START/STOP window and reports error counts via valid/ready.
module ift_sr_monitor #(
   parameter int WIDTH   = 2,
   parameter int TAINT_W = 32
) (
   input  logic               CLK,
   input  logic               SRST,
   input  logic               START,
   input  logic               STOP,
   input  logic [WIDTH-1:0]   SET,
   input  logic [WIDTH-1:0]   CLR,
   input  logic [TAINT_W-1:0] SET_t,
   input  logic [TAINT_W-1:0] CLR_t,
   input  logic [WIDTH-1:0]   Q,
   input  logic [TAINT_W-1:0] Q_t,
   output logic               RES_VALID,
   input  logic               RES_READY,
   output logic               PASS,
   output logic [15:0]        DATA_ERR,
   output logic [15:0]        TAINT_ERR,
   output logic [15:0]        FIRST_FAIL
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

   state_t             state;
   logic [WIDTH-1:0]   ref_q;
   logic [WIDTH-1:0]   exp_q;
   logic [TAINT_W-1:0] exp_t;
   logic [TAINT_W-1:0] exp_t_nxt;
   logic [15:0]        sample_idx;
   logic               fail_seen;
   logic               data_mis;
   logic               taint_mis;

   // fail_seen disambiguates a genuine first failure at index 16'hFFFF from "no failure yet"
   always_comb begin
      exp_q     = (ref_q | SET) & ~CLR;
      exp_t_nxt = ((|SET) || (|CLR)) ? (exp_t | SET_t | CLR_t) : exp_t;
      data_mis  = (Q != exp_q);
      taint_mis = (Q_t != exp_t_nxt);
   end

   always_ff @(posedge CLK) begin
      if (SRST) begin
         state      <= IDLE;
         RES_VALID  <= 1'b0;
         PASS       <= 1'b0;
         DATA_ERR   <= '0;
         TAINT_ERR  <= '0;
         FIRST_FAIL <= '1;
         fail_seen  <= 1'b0;
         ref_q      <= '0;
         exp_t      <= '0;
         sample_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (START) begin
                  state      <= RUN;
                  PASS       <= 1'b0;
                  DATA_ERR   <= '0;
                  TAINT_ERR  <= '0;
                  FIRST_FAIL <= '1;
                  fail_seen  <= 1'b0;
                  ref_q      <= '0;
                  exp_t      <= '0;
                  sample_idx <= '0;
               end
            end
            RUN: begin
               ref_q      <= exp_q;
               exp_t      <= exp_t_nxt;
               sample_idx <= sample_idx + 16'd1;
               if (data_mis && (DATA_ERR != 16'hFFFF))
                  DATA_ERR <= DATA_ERR + 16'd1;
               if (taint_mis && (TAINT_ERR != 16'hFFFF))
                  TAINT_ERR <= TAINT_ERR + 16'd1;
               if ((data_mis || taint_mis) && !fail_seen) begin
                  FIRST_FAIL <= sample_idx;
                  fail_seen  <= 1'b1;
               end
               if (STOP)
                  state <= DRAIN;
            end
            DRAIN: begin
               state     <= REPORT;
               RES_VALID <= 1'b1;
               PASS      <= (DATA_ERR == 16'd0) && (TAINT_ERR == 16'd0);
            end
            REPORT: begin
               if (RES_READY) begin
                  state     <= IDLE;
                  RES_VALID <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ift_sr_monitor.sv
// Randomized self-checking bench for ift_sr_monitor against a transaction-level
// model of the check window, plus directed cases for priority, taint, handshake and saturation.
module tb_ift_sr_monitor;

   localparam int W  = 2;
   localparam int TW = 32;

   logic          CLK = 1'b0;
   logic          SRST = 1'b1;
   logic          START = 1'b0;
   logic          STOP = 1'b0;
   logic [W-1:0]  SET = '0;
   logic [W-1:0]  CLR = '0;
   logic [TW-1:0] SET_t = '0;
   logic [TW-1:0] CLR_t = '0;
   logic [W-1:0]  Q = '0;
   logic [TW-1:0] Q_t = '0;
   logic          RES_READY = 1'b0;
   logic          RES_VALID;
   logic          PASS;
   logic [15:0]   DATA_ERR;
   logic [15:0]   TAINT_ERR;
   logic [15:0]   FIRST_FAIL;

   int n_tests = 0;
   int n_fail  = 0;

   ift_sr_monitor #(.WIDTH(W), .TAINT_W(TW)) dut (
      .CLK(CLK), .SRST(SRST), .START(START), .STOP(STOP),
      .SET(SET), .CLR(CLR), .SET_t(SET_t), .CLR_t(CLR_t),
      .Q(Q), .Q_t(Q_t),
      .RES_VALID(RES_VALID), .RES_READY(RES_READY), .PASS(PASS),
      .DATA_ERR(DATA_ERR), .TAINT_ERR(TAINT_ERR), .FIRST_FAIL(FIRST_FAIL)
   );

   always #5 CLK = ~CLK;

   // Window model: "waiting", "collecting", "draining" and "holding result"
   localparam int P_WAIT = 0, P_COLLECT = 1, P_DRAIN = 2, P_HOLD = 3;
   int            m_phase = P_WAIT;
   bit [W-1:0]    m_q;
   bit [TW-1:0]   m_t;
   int            m_idx, m_derr, m_terr, m_ff;
   bit            m_seen, m_pass;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit [W-1:0] model_q(input bit [W-1:0] s, input bit [W-1:0] c);
      bit [W-1:0] r;
      for (int i = 0; i < W; i++) begin
         if (c[i])      r[i] = 1'b0;
         else if (s[i]) r[i] = 1'b1;
         else           r[i] = m_q[i];
      end
      return r;
   endfunction

   function automatic bit [TW-1:0] model_t(input bit [W-1:0] s, input bit [W-1:0] c,
                                           input bit [TW-1:0] st, input bit [TW-1:0] ct);
      if (s != 0 || c != 0) return m_t | st | ct;
      return m_t;
   endfunction

   task automatic model_clear();
      m_q = '0; m_t = '0; m_idx = 0; m_derr = 0; m_terr = 0; m_ff = 16'hFFFF; m_seen = 0; m_pass = 0;
   endtask

   // Advance the model for the coming edge, take the edge, then compare all outputs.
   task automatic tick();
      bit [W-1:0]  eq;
      bit [TW-1:0] et;
      if (SRST) begin
         m_phase = P_WAIT;
         model_clear();
      end else begin
         case (m_phase)
            P_WAIT: if (START) begin m_phase = P_COLLECT; model_clear(); end
            P_COLLECT: begin
               eq = model_q(SET, CLR);
               et = model_t(SET, CLR, SET_t, CLR_t);
               if (Q != eq)   m_derr = (m_derr < 65535) ? m_derr + 1 : 65535;
               if (Q_t != et) m_terr = (m_terr < 65535) ? m_terr + 1 : 65535;
               if ((Q != eq || Q_t != et) && !m_seen) begin m_ff = m_idx; m_seen = 1; end
               m_q = eq; m_t = et;
               m_idx = (m_idx + 1) % 65536;
               if (STOP) m_phase = P_DRAIN;
            end
            P_DRAIN: begin m_phase = P_HOLD; m_pass = (m_derr == 0 && m_terr == 0); end
            default: if (RES_READY) m_phase = P_WAIT;
         endcase
      end
      @(posedge CLK); #1;
      check("res_valid", RES_VALID, m_phase == P_HOLD);
      check("pass", PASS, m_pass);
      check("data_err", DATA_ERR, m_derr);
      check("taint_err", TAINT_ERR, m_terr);
      check("first_fail", FIRST_FAIL, m_ff);
   endtask

   task automatic apply(input logic [W-1:0] s, c, input logic [TW-1:0] st, ct,
                        input logic [W-1:0] q, input logic [TW-1:0] qt);
      SET = s; CLR = c; SET_t = st; CLR_t = ct; Q = q; Q_t = qt;
      tick();
   endtask

   // One sample with Q/Q_t following the model unless an error is injected.
   task automatic samp(input logic [W-1:0] s, c, input logic [TW-1:0] st, ct,
                       input bit bad_q, input bit bad_t);
      bit [W-1:0]  eq;
      bit [TW-1:0] et;
      eq = model_q(s, c);
      et = model_t(s, c, st, ct);
      apply(s, c, st, ct, bad_q ? ~eq : eq, bad_t ? (et ^ 32'h1) : et);
   endtask

   task automatic open_window();
      START = 1; SET = '0; CLR = '0; tick(); START = 0;
   endtask

   // Last sample carries STOP; then one drain cycle, leaving the result presented.
   task automatic close_window(input logic [W-1:0] s, c, input bit bad_q);
      STOP = 1; samp(s, c, '0, '0, bad_q, 0); STOP = 0;
      SET = '0; CLR = '0;
      tick();
   endtask

   task automatic accept();
      RES_READY = 1; tick(); RES_READY = 0;
   endtask

   initial begin
      model_clear();
      tick(); tick();
      SRST = 0;
      check("rst_ff", FIRST_FAIL, 16'hFFFF);
      check("rst_valid", RES_VALID, 0);

      // Clean sequence
      open_window();
      samp(2'b00, 2'b00, 0, 0, 0, 0);
      samp(2'b00, 2'b10, 0, 0, 0, 0);
      samp(2'b00, 2'b11, 0, 0, 0, 0);
      samp(2'b01, 2'b00, 0, 0, 0, 0);
      samp(2'b11, 2'b00, 0, 0, 0, 0);
      close_window(2'b10, 2'b00, 0);
      check("clean_valid", RES_VALID, 1);
      check("clean_pass", PASS, 1);
      check("clean_derr", DATA_ERR, 0);
      check("clean_ff", FIRST_FAIL, 16'hFFFF);
      accept();
      check("clean_idle_pass", PASS, 1);

      // CLR priority over SET
      open_window();
      apply(2'b11, 2'b10, 0, 0, 2'b01, 0);
      apply(2'b00, 2'b11, 0, 0, 2'b00, 0);
      apply(2'b11, 2'b10, 0, 0, 2'b11, 0);
      close_window(2'b00, 2'b00, 0);
      check("prio_derr", DATA_ERR, 1);
      check("prio_ff", FIRST_FAIL, 2);
      check("prio_pass", PASS, 0);
      accept();

      // Sticky taint, then a 5-cycle stall in the result state
      open_window();
      apply(2'b01, 2'b00, 32'h1, 32'h100, 2'b01, 32'h101);
      apply(2'b00, 2'b00, 32'h2, 32'h0,   2'b01, 32'h101);
      apply(2'b00, 2'b00, 32'h0, 32'h0,   2'b01, 32'h0);
      STOP = 1; apply(2'b00, 2'b00, 0, 0, 2'b01, 32'h101); STOP = 0;
      tick();
      check("taint_terr", TAINT_ERR, 1);
      check("taint_ff", FIRST_FAIL, 2);
      for (int i = 0; i < 5; i++) begin
         START = 1; tick(); START = 0;
      end
      check("hs_valid", RES_VALID, 1);
      accept();
      check("hs_idle", RES_VALID, 0);

      // Randomized windows with spurious START/STOP and random ready delay
      for (int w = 0; w < 25; w++) begin
         int n;
         STOP = ($urandom_range(0, 3) == 0);
         open_window();
         STOP = 0;
         n = $urandom_range(1, 40);
         for (int k = 0; k < n; k++) begin
            START = ($urandom_range(0, 9) == 0);
            samp(W'($urandom), W'($urandom),
                 $urandom & $urandom & $urandom, $urandom & $urandom & $urandom,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
         end
         START = 0;
         close_window(W'($urandom), W'($urandom), $urandom_range(0, 7) == 0);
         for (int d = $urandom_range(0, 5); d > 0; d--) tick();
         accept();
         for (int d = $urandom_range(0, 3); d > 0; d--) begin
            STOP = $urandom_range(0, 1); tick(); STOP = 0;
         end
      end

      // Saturation with index wrap
      open_window();
      for (int k = 0; k < 70000; k++) samp(W'($urandom), W'($urandom), 0, 0, 1, 0);
      close_window(2'b00, 2'b00, 1);
      check("sat_derr", DATA_ERR, 16'hFFFF);
      check("sat_ff", FIRST_FAIL, 0);
      accept();

      // Reset mid-window, then a window with a single clean sample
      open_window();
      samp(2'b01, 2'b00, 0, 0, 0, 0);
      samp(2'b10, 2'b00, 0, 0, 1, 0);
      samp(2'b00, 2'b01, 0, 0, 0, 0);
      SRST = 1; tick(); SRST = 0;
      check("mid_rst_derr", DATA_ERR, 0);
      check("mid_rst_ff", FIRST_FAIL, 16'hFFFF);
      check("mid_rst_pass", PASS, 0);
      open_window();
      close_window(2'b00, 2'b00, 0);
      check("empty_pass", PASS, 1);
      RES_READY = 1; SRST = 1; tick(); SRST = 0; RES_READY = 0;
      check("rpt_rst_valid", RES_VALID, 0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
